conv11_mac_accum: RTL and testbench
===================================

Name: conv11_mac_accum

Overview:
- Compute stage directly downstream of the 1x1-conv input stage; consumes its out_0_0 byte stream, one input channel per beat.
- Multiplies each beat by a per-channel signed weight and accumulates IN_CH beats into one output pixel.
- Adds bias, rounds/shifts/saturates back to DATA_WIDTH, optional ReLU, and presents the pixel on a valid/ready output.
- Weights and bias are loaded through a simple write port while idle.

Parameters:
- DATA_WIDTH, 8: signed width of input activations and output pixel.
- WEIGHT_WIDTH, 8: signed weight width.
- ACC_WIDTH, 24: signed accumulator/bias width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(IN_CH).
- IN_CH, 16: beats (input channels) per output pixel; >= 2.
- OUT_SHIFT, 7: arithmetic right shift for requantisation; 0 allowed.
- RELU_EN, 1: 1 clamps negative results to 0 after saturation.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input-stage byte valid.
- in_data  in  DATA_WIDTH  signed activation (from out_0_0).
- in_read_en  out  1  consume strobe to input stage (drives its inputbuf_read_en).
- w_load  in  1  weight/bias write strobe.
- w_addr  in  clog2(IN_CH+1)  0..IN_CH-1 selects a weight, IN_CH selects bias.
- w_data  in  ACC_WIDTH  write data; weights use low WEIGHT_WIDTH bits.
- out_valid  out  1  result pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  signed result pixel.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, ch counter=0, acc=0, product reg/valid=0, out_valid=0, out_data=0, busy=0. Weight and bias registers also clear to 0.
- Reset mid-pixel discards all partial work. Input-stage data already consumed is lost; upstream re-issues.
- Beat accepted when in_valid && in_read_en.
- in_read_en = (state==IDLE && !w_load) || (state==ACCUM && ch<IN_CH). Combinational, no dependency on in_valid.
- FSM states and transitions:
  - IDLE: a write occurs when w_load=1 (weight[w_addr] or bias, next edge). Otherwise an accepted beat is channel 0; ch<=1, go to ACCUM. w_addr > IN_CH is ignored.
  - ACCUM: each accepted beat registers product = in_data*weight[ch], signed full width; ch++. The previous product is added into acc, sign-extended to ACC_WIDTH. On the beat with ch==IN_CH-1, go to DRAIN and drop in_read_en.
  - DRAIN (1 cycle): last product added. Compute r = (acc+bias + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT. Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then ReLU if enabled. Register r into out_data, set out_valid, go to OUTPUT.
  - OUTPUT: out_data/out_valid stable until out_ready. On out_valid&&out_ready: out_valid<=0, acc<=0, ch<=0, go to IDLE.
- No pixel overlap: the next pixel's first beat is accepted no earlier than the cycle after the output handshake.
- Gaps in in_valid during ACCUM stall without losing state. acc only updates on cycles where the product reg is valid.
- Latency: out_valid rises 2 edges after the edge accepting the last beat, with out_ready ignored until then.
- w_load outside IDLE is ignored, with no side effects. In IDLE, w_load has priority over beat acceptance (in_read_en low).
- Overflow: acc wraps per ACC_WIDTH. The width rule above guarantees no wrap for legal parameters.

Decomposition:
- Shared package conv11_pkg: state encoding (IDLE/ACCUM/DRAIN/OUTPUT), sat/round helper function, clog2 constant helper.
- One natural sub-module: conv11_requant, combinational. It takes acc+bias, does round/shift/saturate/ReLU, and is parameterised by ACC_WIDTH, DATA_WIDTH, OUT_SHIFT, RELU_EN.
- Weight register file stays inline.

Test Plan:
- Bench override IN_CH=4, OUT_SHIFT=0, RELU_EN=0 for all scenarios except the rounding one.
- Basic: weights 1,1,1,1, bias 0; beats 10,20,30,40 back-to-back -> out_data=100, out_valid 2 edges after 4th accept, busy high throughout.
- Saturation: weights all 127; beats 127 x4 -> 127. Weights all -128 with beats 127 -> -128. RELU_EN=1 on the second case -> 0.
- Rounding (OUT_SHIFT=2): weights 1,0,0,0, bias 0; first beat 6 -> 2; first beat -6 -> -1; first beat 5 -> 1.
- Backpressure: out_ready low 5 cycles after out_valid -> out_data held constant, in_read_en=0, in_valid beats not consumed. Release -> handshake, IDLE, next pixel accepted next cycle.
- Stall + weight guard:
  - in_valid gaps of 3 cycles between beats -> same 100 result.
  - w_load during ACCUM with w_addr=0, w_data=99 -> ignored, weight stays 1.
  - w_load in IDLE with w_addr=4, w_data=-50 -> next basic pixel = 50.
- Reset mid-ACCUM: drop rst after 2 beats -> out_valid=0, state IDLE. A fresh 4-beat pixel yields a correct independent result.

Source files
------------

// File: rtl/conv11_pkg.sv
// Shared definitions for the 1x1-conv MAC accumulator: FSM encoding and
// constant/requantisation helper functions.
package conv11_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Round-half-up then arithmetic shift; a zero shift passes the value through.
  function automatic longint round_shift(input longint value, input int shift);
    longint half;
    if (shift <= 0) return value;
    half = longint'(1) <<< (shift - 1);
    return (value + half) >>> shift;
  endfunction

  function automatic longint sat_clamp(input longint value, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv11_requant.sv
// Combinational requantiser: rounds/shifts the biased accumulator, saturates
// to the output width and optionally applies ReLU.
module conv11_requant
  import conv11_pkg::*;
#(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_SHIFT  = 7,
  parameter int RELU_EN    = 1
) (
  input  logic [ACC_WIDTH-1:0]  sum,
  output logic [DATA_WIDTH-1:0] result
);

  longint wide;
  longint scaled;
  longint clamped;

  always_comb begin
    wide    = longint'($signed(sum));
    scaled  = round_shift(wide, OUT_SHIFT);
    clamped = sat_clamp(scaled, DATA_WIDTH);
    if (RELU_EN != 0 && clamped < 0) clamped = 0;
    result  = clamped[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/conv11_mac_accum.sv
// 1x1-conv MAC stage: multiplies one channel per beat by its weight, sums
// IN_CH beats, adds bias and requantises into one output pixel.
module conv11_mac_accum
  import conv11_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int IN_CH        = 16,
  parameter int OUT_SHIFT    = 7,
  parameter int RELU_EN      = 1,
  localparam int ADDR_WIDTH  = clog2_f(IN_CH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_read_en,
  input  logic                  w_load,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ACC_WIDTH-1:0]  w_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int IDX_WIDTH  = clog2_f(IN_CH);
  localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(IN_CH - 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_CH  = ADDR_WIDTH'(IN_CH);

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         ch;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   bias;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic                          prod_valid;
  logic signed [WEIGHT_WIDTH-1:0] weight [IN_CH];

  logic                          beat;
  logic                          idle_write;
  logic signed [PROD_WIDTH-1:0]  prod_next;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]          requant_sum;
  logic [DATA_WIDTH-1:0]         requant_data;

  assign in_read_en  = (state == ST_IDLE && !w_load) || (state == ST_ACCUM && ch < NUM_CH);
  assign beat        = in_valid && in_read_en;
  assign idle_write  = (state == ST_IDLE) && w_load;
  assign busy        = (state != ST_IDLE);
  // ch is 0 in IDLE, so the same index serves the first beat of a pixel.
  assign prod_next   = $signed(in_data) * weight[ch[IDX_WIDTH-1:0]];
  assign prod_ext    = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign requant_sum = acc + bias;

  genvar gi;
  generate
    for (gi = 0; gi < IN_CH; gi++) begin : g_weight
      logic signed [WEIGHT_WIDTH-1:0] w_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          w_reg <= '0;
        end else if (idle_write && w_addr == ADDR_WIDTH'(gi)) begin
          w_reg <= w_data[WEIGHT_WIDTH-1:0];
        end
      end
      assign weight[gi] = w_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias <= '0;
    end else if (idle_write && w_addr == NUM_CH) begin
      bias <= $signed(w_data);
    end
  end

  conv11_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_SHIFT (OUT_SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_requant (
    .sum   (requant_sum),
    .result(requant_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ch         <= '0;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      prod_valid <= beat;
      if (beat) prod <= prod_next;
      if (prod_valid) acc <= acc + prod_ext;
      case (state)
        ST_IDLE: begin
          if (beat) begin
            ch    <= ADDR_WIDTH'(1);
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            ch <= ch + ADDR_WIDTH'(1);
            if (ch == LAST_CH) state <= ST_DRAIN;
          end
        end
        // Wait for the final product to land in acc before requantising.
        ST_DRAIN: begin
          if (!prod_valid) begin
            out_data  <= requant_data;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ch        <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv11_mac_accum.sv
// Bench for conv11_mac_accum: three instances (plain, rounding, ReLU) share
// stimulus and are compared against an arithmetic pixel model.
module tb_conv11_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        w_load;
  logic [2:0]  w_addr;
  logic [23:0] w_data;
  logic        out_ready;
  logic        rd_a, rd_r, rd_l, ov_a, ov_r, ov_l, busy_a, busy_r, busy_l;
  logic [7:0]  od_a, od_r, od_l;

  always #5 clk = ~clk;

  conv11_mac_accum #(.IN_CH(4), .OUT_SHIFT(0), .RELU_EN(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_read_en(rd_a),
    .w_load(w_load), .w_addr(w_addr), .w_data(w_data), .out_valid(ov_a),
    .out_ready(out_ready), .out_data(od_a), .busy(busy_a));
  conv11_mac_accum #(.IN_CH(4), .OUT_SHIFT(2), .RELU_EN(0)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_read_en(rd_r),
    .w_load(w_load), .w_addr(w_addr), .w_data(w_data), .out_valid(ov_r),
    .out_ready(out_ready), .out_data(od_r), .busy(busy_r));
  conv11_mac_accum #(.IN_CH(4), .OUT_SHIFT(0), .RELU_EN(1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_read_en(rd_l),
    .w_load(w_load), .w_addr(w_addr), .w_data(w_data), .out_valid(ov_l),
    .out_ready(out_ready), .out_data(od_l), .busy(busy_l));

  int errors = 0;
  int checks = 0;

  int w_sh[4];
  int bias_sh;

  int pix_beats[4];
  int pix_gap;
  int pix_bp;
  bit pix_guard;
  int obs[3];
  int obs_lat, busy_bad, hold_bad, read_bad, post_bad, timed_out;

  localparam int SHIFTS[3] = '{0, 2, 0};
  localparam int RELUS[3]  = '{0, 0, 1};

  // Sum of products plus bias, then floor((s + d/2) / d), clamp, optional ReLU.
  function automatic int model_pixel(input int b[4], input int shift, input int relu);
    longint s, d, q, r;
    s = longint'(bias_sh);
    for (int i = 0; i < 4; i++) s += longint'(b[i]) * longint'(w_sh[i]);
    if (shift > 0) begin
      d = longint'(1) << shift;
      q = s + d / 2;
      r = q / d;
      if (q < 0 && (q % d) != 0) r -= 1;
    end else begin
      r = s;
    end
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (relu != 0 && r < 0) r = 0;
    return int'(r);
  endfunction

  task automatic load_word(input int addr, input int val);
    w_load = 1'b1;
    w_addr = 3'(addr);
    w_data = 24'(val);
    @(posedge clk); #1;
    w_load = 1'b0;
    if (addr < 4) w_sh[addr] = int'($signed(8'(val)));
    else if (addr == 4) bias_sh = val;
  endtask

  task automatic load_weights(input int w0, input int w1, input int w2, input int w3, input int b);
    load_word(0, w0);
    load_word(1, w1);
    load_word(2, w2);
    load_word(3, w3);
    load_word(4, b);
  endtask

  // Drives one pixel, waits for the result, applies backpressure, handshakes.
  task automatic run_pixel();
    int  idx, gapc, cyc, c;
    logic took;
    logic [7:0] held_a, held_r, held_l;
    idx = 0; gapc = 0; cyc = 0;
    busy_bad = 0; hold_bad = 0; read_bad = 0; post_bad = 0; timed_out = 0;
    while (idx < 4 && cyc < 200) begin
      if (gapc > 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); gapc--;
      end else begin
        in_valid = 1'b1; in_data = 8'(pix_beats[idx]);
      end
      if (pix_guard && idx == 2) begin
        w_load = 1'b1; w_addr = 3'd0; w_data = 24'd99;
      end else begin
        w_load = 1'b0;
      end
      #1;
      took = in_valid && rd_a;
      if ((idx > 0) != busy_a || busy_r !== busy_a || busy_l !== busy_a) busy_bad++;
      if (rd_r !== rd_a || rd_l !== rd_a) read_bad++;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        gapc = (pix_gap < 0) ? int'($urandom_range(0, 3)) : pix_gap;
      end
      cyc++;
    end
    w_load = 1'b0;
    if (idx < 4) timed_out = 1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    obs_lat  = 0;
    while (!ov_a && obs_lat < 20) begin
      #1;
      if (rd_a || rd_r || rd_l) read_bad++;
      if (!busy_a) busy_bad++;
      @(posedge clk); #1;
      obs_lat++;
    end
    if (!ov_a || !ov_r || !ov_l) timed_out = 1;
    obs[0] = int'($signed(od_a));
    obs[1] = int'($signed(od_r));
    obs[2] = int'($signed(od_l));
    held_a = od_a; held_r = od_r; held_l = od_l;
    for (c = 0; c < pix_bp; c++) begin
      #1;
      if (rd_a || rd_r || rd_l) read_bad++;
      @(posedge clk); #1;
      if (!ov_a || !ov_r || !ov_l || od_a !== held_a || od_r !== held_r || od_l !== held_l)
        hold_bad++;
    end
    out_ready = 1'b1;
    #1;
    if (rd_a) read_bad++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (ov_a || ov_r || ov_l || busy_a || busy_l) post_bad++;
    if (!rd_a) post_bad++;
  endtask

  task automatic compare_pixel(input string name);
    int exp_v;
    for (int k = 0; k < 3; k++) begin
      exp_v = model_pixel(pix_beats, SHIFTS[k], RELUS[k]);
      checks++;
      if (obs[k] !== exp_v) begin
        errors++;
        $display("FAIL %s dut%0d out_data got %0d expected %0d", name, k, obs[k], exp_v);
      end
    end
    checks++;
    if (timed_out !== 0) begin
      errors++;
      $display("FAIL %s timeout got %0d expected 0", name, timed_out);
    end
    $display("pixel %s beats %0d %0d %0d %0d -> %0d %0d %0d lat=%0d", name, pix_beats[0],
             pix_beats[1], pix_beats[2], pix_beats[3], obs[0], obs[1], obs[2], obs_lat);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; w_load = 1'b0; w_addr = '0; w_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov_a, ov_r, ov_l} !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid got %b expected 000", {ov_a, ov_r, ov_l});
    end
    checks++;
    if ({od_a, od_r, od_l} !== 24'd0) begin
      errors++; $display("FAIL reset_out_data got %h expected 0", {od_a, od_r, od_l});
    end
    checks++;
    if ({busy_a, busy_r, busy_l} !== 3'b000) begin
      errors++; $display("FAIL reset_busy got %b expected 000", {busy_a, busy_r, busy_l});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_a !== 1'b1) begin
      errors++; $display("FAIL reset_read_en got %b expected 1", rd_a);
    end
    w_sh = '{0, 0, 0, 0}; bias_sh = 0;
    pix_beats = '{10, 20, 30, 40}; pix_gap = 0; pix_bp = 0; pix_guard = 0;
    run_pixel();
    compare_pixel("reset_zero_weights");
  endtask

  task automatic test_basic();
    load_weights(1, 1, 1, 1, 0);
    pix_beats = '{10, 20, 30, 40}; pix_gap = 0; pix_bp = 0; pix_guard = 0;
    run_pixel();
    compare_pixel("basic");
    checks++;
    if (obs[0] !== 100) begin
      errors++; $display("FAIL basic_value got %0d expected 100", obs[0]);
    end
    checks++;
    if (obs_lat !== 2) begin
      errors++; $display("FAIL basic_latency got %0d expected 2", obs_lat);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL basic_busy got %0d bad cycles expected 0", busy_bad);
    end
  endtask

  task automatic test_saturation();
    load_weights(127, 127, 127, 127, 0);
    pix_beats = '{127, 127, 127, 127}; pix_gap = 0; pix_bp = 0; pix_guard = 0;
    run_pixel();
    compare_pixel("sat_pos");
    load_weights(-128, -128, -128, -128, 0);
    run_pixel();
    compare_pixel("sat_neg");
    checks++;
    if (obs[2] !== 0) begin
      errors++; $display("FAIL sat_relu got %0d expected 0", obs[2]);
    end
  endtask

  task automatic test_rounding();
    int vals[3];
    int want[3];
    vals = '{6, -6, 5};
    want = '{2, -1, 1};
    load_weights(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pix_beats[0] = vals[i];
      for (int j = 1; j < 4; j++) pix_beats[j] = int'($signed(8'($urandom)));
      pix_gap = 0; pix_bp = 0; pix_guard = 0;
      run_pixel();
      compare_pixel("rounding");
      checks++;
      if (obs[1] !== want[i]) begin
        errors++; $display("FAIL rounding_shift2 got %0d expected %0d", obs[1], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    load_weights(1, 1, 1, 1, 0);
    for (int j = 0; j < 4; j++) pix_beats[j] = int'($signed(8'($urandom)));
    pix_gap = 0; pix_bp = 5; pix_guard = 0;
    run_pixel();
    compare_pixel("backpressure");
    checks++;
    if (hold_bad !== 0) begin
      errors++; $display("FAIL bp_hold got %0d bad cycles expected 0", hold_bad);
    end
    checks++;
    if (read_bad !== 0) begin
      errors++; $display("FAIL bp_read_en got %0d bad cycles expected 0", read_bad);
    end
    checks++;
    if (post_bad !== 0) begin
      errors++; $display("FAIL bp_handshake got %0d bad expected 0", post_bad);
    end
  endtask

  task automatic test_stall_guard();
    pix_beats = '{10, 20, 30, 40}; pix_gap = 3; pix_bp = 0; pix_guard = 1;
    run_pixel();
    compare_pixel("stall_guard");
    checks++;
    if (obs[0] !== 100) begin
      errors++; $display("FAIL stall_value got %0d expected 100", obs[0]);
    end
    pix_gap = 0; pix_guard = 0;
    run_pixel();
    compare_pixel("after_guard");
    w_load = 1'b1; w_addr = 3'd4; w_data = 24'(-50);
    #1;
    checks++;
    if (rd_a !== 1'b0) begin
      errors++; $display("FAIL idle_wload_read_en got %b expected 0", rd_a);
    end
    @(posedge clk); #1;
    w_load = 1'b0;
    bias_sh = -50;
    load_word(7, 1000);
    run_pixel();
    compare_pixel("bias_minus50");
    checks++;
    if (obs[0] !== 50) begin
      errors++; $display("FAIL bias_value got %0d expected 50", obs[0]);
    end
  endtask

  task automatic test_reset_mid();
    load_weights(1, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(7 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({ov_a, busy_a, busy_r, busy_l} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got %b expected 0000", {ov_a, busy_a, busy_r, busy_l});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    w_sh = '{0, 0, 0, 0}; bias_sh = 0;
    load_weights($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 13);
    for (int j = 0; j < 4; j++) pix_beats[j] = int'($signed(8'($urandom)));
    pix_gap = 0; pix_bp = 0; pix_guard = 0;
    run_pixel();
    compare_pixel("after_mid_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      load_weights($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                   $urandom_range(0, 400) - 200);
      for (int j = 0; j < 4; j++) pix_beats[j] = int'($signed(8'($urandom)));
      pix_gap = -1; pix_bp = $urandom_range(0, 3); pix_guard = 0;
      run_pixel();
      compare_pixel("random");
      checks++;
      if (obs_lat !== 2) begin
        errors++; $display("FAIL random_latency got %0d expected 2", obs_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_stall_guard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
